riscv_mem_arb: RTL and testbench
================================

RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 The module SHALL have the parameter AW, default 32, meaning address width.
REQ-002 The module SHALL have the parameter DW, default 32, meaning data width.
REQ-003 The module SHALL have the parameter TIMEOUT, default 255, meaning maximum wait cycles for mem_ack_i; a value of 0 disables the timeout.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with the ports listed in REQ-005 and REQ-006.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 inst_req_i  in  1  fetch request, held high until inst_ack_o.
REQ-008 inst_addr_i  in  AW  fetch address, stable while inst_req_i is high.
REQ-009 inst_ack_o  out  1  fetch complete, one-cycle pulse.
REQ-010 inst_o  out  DW  fetched word, valid when inst_ack_o is high.
REQ-011 data_req_i  in  1  load/store request, held high until data_ack_o.
REQ-012 data_we_i  in  1  1 = store, 0 = load.
REQ-013 data_addr_i  in  AW  data address.
REQ-014 data_wdata_i  in  DW  store data.
REQ-015 data_ack_o  out  1  data access complete, one-cycle pulse.
REQ-016 data_o  out  DW  load data, valid when data_ack_o is high.
REQ-017 mem_req_o  out  1  request to the shared memory.
REQ-018 mem_we_o  out  1  write enable to the shared memory.
REQ-019 mem_addr_o  out  AW  shared memory address.
REQ-020 mem_wdata_o  out  DW  shared memory write data.
REQ-021 mem_ack_i  in  1  memory done, one-cycle pulse; mem_rdata_i valid in the same cycle.
REQ-022 mem_rdata_i  in  DW  memory read data.
REQ-023 err_o  out  1  timeout abort, one-cycle pulse.

Function
REQ-024 The FSM SHALL have exactly the states IDLE, INST and DATA.
REQ-025 In IDLE with any request pending, the FSM SHALL take a registered grant: it latches the address, we and wdata of the winner and enters INST or DATA on the next edge.
REQ-026 Latency: a request first seen in IDLE at cycle N SHALL give mem_req_o=1 at cycle N+1.
REQ-027 The default arbitration SHALL be fixed priority, data over inst, when both requests are high in IDLE.
REQ-028 In INST or DATA, mem_req_o SHALL be 1 and mem_addr_o, mem_we_o and mem_wdata_o SHALL be driven from the latched registers, held constant until the access ends.
REQ-029 In INST, mem_we_o SHALL be 0.
REQ-030 On mem_ack_i in the INST state, inst_ack_o SHALL pulse and inst_o SHALL equal mem_rdata_i in that same cycle (combinational pass-through).
REQ-031 On mem_ack_i in the DATA state, data_ack_o and data_o SHALL behave the same way as REQ-030.
REQ-032 After an ack, the FSM SHALL return to IDLE; there is a minimum of one IDLE cycle between accesses, so a stale request is never re-granted.
REQ-033 mem_ack_i received in IDLE SHALL be ignored and SHALL produce no ack output.
REQ-034 A 16-bit wait counter SHALL clear on grant and increment each cycle in INST or DATA without mem_ack_i.
REQ-035 With TIMEOUT != 0, when the counter reaches TIMEOUT, err_o SHALL pulse, the granted requester's ack SHALL pulse with data forced to 0, mem_req_o SHALL drop, and the FSM SHALL return to IDLE.
REQ-036 If mem_ack_i arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: normal completion, err_o stays 0.
REQ-037 Requests deasserted before their ack are a protocol violation; the access SHALL still complete and its ack SHALL still be issued.

Reset
REQ-038 Asserting rst low SHALL immediately put the FSM in IDLE, including mid-access, abandoning the access with no ack and no err.
REQ-039 During reset, mem_req_o, mem_we_o, inst_ack_o, data_ack_o and err_o SHALL be 0.
REQ-040 During reset, the latched address and data registers, inst_o, data_o and the wait counter SHALL be 0.
REQ-041 The round-robin pointer SHALL reset to favour data first.

Configuration
REQ-042 With the macro RISCV_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit last-grant register updates on each grant, and when both requesters are pending the one not granted last wins.
REQ-043 With RISCV_ARB_RR_EN undefined, arbitration SHALL be the fixed priority of REQ-027 and no pointer register SHALL exist.

Verification
REQ-044 Scenario: inst_req_i=1, addr 0x100, mem acks after 2 cycles with 0xDEADBEEF -> mem_req_o at N+1, inst_ack_o pulse with inst_o=0xDEADBEEF, then IDLE.
REQ-045 Scenario: data store, addr 0x2000, wdata 0x12345678 -> mem_we_o=1 with exact address and wdata held until ack; one data_ack_o pulse.
REQ-046 Scenario: both requests high together, repeated 4 times -> fixed build: data granted first each round; with RISCV_ARB_RR_EN: grants alternate data, inst, data, inst.
REQ-047 Scenario: TIMEOUT=8 with no mem_ack_i -> err_o and ack pulse at wait count 8 with data 0; mem_req_o low next cycle.
REQ-048 Scenario: mem_ack_i coincident with the timeout cycle -> normal ack with read data, err_o=0.
REQ-049 Scenario: rst driven low mid-access, then released -> all outputs 0 asynchronously; no ack; the next request is granted from IDLE.

Source files
------------

// File: rtl/riscv_mem_arb.sv
// -----------------------------------------------------------------------------
// riscv_mem_arb
//
// Purpose:
//   Arbitrates a RISC-V core's instruction-fetch port and its load/store port
//   onto one shared single-port memory bus. Only one access is in flight at a
//   time. A 3-state FSM (IDLE / INST / DATA) takes a registered grant in IDLE
//   and latches the winner's address, write enable and write data. It then
//   presents a request to memory until either mem_ack_i or a wait-cycle
//   timeout ends the access.
//
// Configuration macro:
//   RISCV_ARB_RR_EN  - defined  : round-robin arbitration between the two
//                                 requesters (1-bit last-grant pointer).
//                      undefined: fixed priority, data port wins over fetch.
//
// Parameters:
//   AW       address width
//   DW       data width
//   TIMEOUT  wait cycles allowed before an access is aborted (0 = never)
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   inst_req_i    fetch request (held until inst_ack_o)
//   inst_addr_i   fetch address
//   inst_ack_o    fetch complete, one-cycle pulse
//   inst_o        fetched word, valid with inst_ack_o
//   data_req_i    load/store request (held until data_ack_o)
//   data_we_i     1 = store, 0 = load
//   data_addr_i   load/store address
//   data_wdata_i  store data
//   data_ack_o    load/store complete, one-cycle pulse
//   data_o        load data, valid with data_ack_o
//   mem_req_o     request to shared memory
//   mem_we_o      write enable to shared memory
//   mem_addr_o    shared memory address
//   mem_wdata_o   shared memory write data
//   mem_ack_i     memory done, one-cycle pulse
//   mem_rdata_i   memory read data, valid with mem_ack_i
//   err_o         timeout abort, one-cycle pulse
// -----------------------------------------------------------------------------
module riscv_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req_i,
    input  logic [AW-1:0] inst_addr_i,
    output logic          inst_ack_o,
    output logic [DW-1:0] inst_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic          data_ack_o,
    output logic [DW-1:0] data_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,

    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

    state_t          r_state;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [15:0]     r_wait_cnt;

    logic            w_busy;
    logic            w_any_req;
    logic            w_grant_data;
    logic            w_timeout;
    logic            w_done;

    assign w_busy    = (r_state != IDLE);
    assign w_any_req = inst_req_i | data_req_i;

    // A real ack in the same cycle the counter hits the limit takes precedence,
    // so the timeout term is qualified with !mem_ack_i.
    assign w_timeout = TIMEOUT_EN && w_busy && !mem_ack_i &&
                       (r_wait_cnt == TIMEOUT_CNT);
    assign w_done    = w_busy && (mem_ack_i || w_timeout);

`ifdef RISCV_ARB_RR_EN
    // r_last_data = 1 when the most recent grant went to the data port.
    // Resets to 0 so that data wins the first contested grant.
    logic r_last_data;

    assign w_grant_data = data_req_i && (!inst_req_i || !r_last_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_data <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_data <= w_grant_data;
        end
    end
`else
    assign w_grant_data = data_req_i;
`endif

    // Grant is taken in IDLE and becomes visible on the bus one edge later.
    // Returning to IDLE after every access guarantees one idle cycle, which
    // lets the requester drop its request before arbitration looks again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                        if (w_grant_data) begin
                            r_state  <= DATA;
                            r_mem_we <= data_we_i;
                            r_addr   <= data_addr_i;
                            r_wdata  <= data_wdata_i;
                        end else begin
                            r_state  <= INST;
                            r_mem_we <= 1'b0;
                            r_addr   <= inst_addr_i;
                            r_wdata  <= '0;
                        end
                    end
                end
                INST, DATA: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    // Acks and read data pass straight through from the memory in the ack
    // cycle. On a timeout mem_ack_i is low, so the returned word is forced to 0.
    assign inst_ack_o  = (r_state == INST) && w_done;
    assign data_ack_o  = (r_state == DATA) && w_done;
    assign inst_o      = ((r_state == INST) && mem_ack_i) ? mem_rdata_i : '0;
    assign data_o      = ((r_state == DATA) && mem_ack_i) ? mem_rdata_i : '0;
    assign err_o       = w_timeout;

endmodule

// File: tb/tb_riscv_mem_arb.sv
module tb_riscv_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

`ifdef RISCV_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_req_i = 1'b0;
    logic [AW-1:0] inst_addr_i = '0;
    logic          inst_ack_o;
    logic [DW-1:0] inst_o;
    logic          data_req_i = 1'b0;
    logic          data_we_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_wdata_i = '0;
    logic          data_ack_o;
    logic [DW-1:0] data_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          err_o;

    always #5 clk = ~clk;

    riscv_mem_arb #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req_i   (inst_req_i),
        .inst_addr_i  (inst_addr_i),
        .inst_ack_o   (inst_ack_o),
        .inst_o       (inst_o),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_ack_o   (data_ack_o),
        .data_o       (data_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // One record = one complete access: stimulus plus hand-computed results.
    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        we;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        int          ack_dly;   // busy-cycle index of mem_ack_i (>TO = never)
        logic [31:0] rdata;     // value driven on mem_rdata_i with the ack
        logic        stray;     // drive mem_ack_i in the idle cycle afterwards
        logic        exp_data;  // 1 = data port expected to win
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic [31:0] exp_out;   // expected inst_o / data_o in the ack cycle
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic run_vec(input int idx, input vec_t v);
        int end_k;
        end_k = v.exp_err ? TO : v.ack_dly;

        // Cycle N: request appears while the arbiter is idle.
        @(posedge clk); #1;
        inst_req_i   = v.ireq;
        inst_addr_i  = v.iaddr;
        data_req_i   = v.dreq;
        data_we_i    = v.we;
        data_addr_i  = v.daddr;
        data_wdata_i = v.wdata;
        mem_ack_i    = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_req_at_N", idx), mem_req_o, 0);

        for (int k = 0; k <= end_k; k++) begin
            @(posedge clk); #1;
            mem_ack_i   = (k == v.ack_dly);
            mem_rdata_i = (k == v.ack_dly) ? v.rdata : (32'hBAD0_0000 | k);
            @(negedge clk);
            check($sformatf("v%0d_k%0d_mem_req", idx, k), mem_req_o, 1);
            check($sformatf("v%0d_k%0d_addr", idx, k), mem_addr_o, v.exp_addr);
            check($sformatf("v%0d_k%0d_we", idx, k), mem_we_o, v.exp_we);
            if (v.exp_data)
                check($sformatf("v%0d_k%0d_wdata", idx, k), mem_wdata_o, v.exp_wdata);
            if (k == end_k) begin
                check($sformatf("v%0d_inst_ack", idx), inst_ack_o, !v.exp_data);
                check($sformatf("v%0d_data_ack", idx), data_ack_o, v.exp_data);
                check($sformatf("v%0d_rdata", idx), v.exp_data ? data_o : inst_o, v.exp_out);
                check($sformatf("v%0d_err", idx), err_o, v.exp_err);
            end else begin
                check($sformatf("v%0d_k%0d_acks", idx, k), {err_o, data_ack_o, inst_ack_o}, 0);
            end
        end

        // Requester drops after its ack; the arbiter must sit in IDLE.
        @(posedge clk); #1;
        inst_req_i = 1'b0;
        data_req_i = 1'b0;
        mem_ack_i  = v.stray;
        mem_rdata_i = 32'h7777_7777;
        @(negedge clk);
        check($sformatf("v%0d_idle_req", idx), mem_req_o, 0);
        check($sformatf("v%0d_idle_acks", idx), {err_o, data_ack_o, inst_ack_o}, 0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        $display("txn %0d: ireq=%0b dreq=%0b we=%0b winner=%s addr=0x%08h err=%0b",
                 idx, v.ireq, v.dreq, v.we, v.exp_data ? "data" : "inst",
                 v.exp_addr, v.exp_err);
    endtask

    function automatic vec_t mk(input logic ireq, input logic dreq, input logic we,
                                input logic [31:0] iaddr, input logic [31:0] daddr,
                                input logic [31:0] wdata, input int dly,
                                input logic [31:0] rdata, input logic stray,
                                input logic exp_data, input logic exp_err);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.we = we;
        v.iaddr = iaddr; v.daddr = daddr; v.wdata = wdata;
        v.ack_dly = dly; v.rdata = rdata; v.stray = stray;
        v.exp_data  = exp_data;
        v.exp_addr  = exp_data ? daddr : iaddr;
        v.exp_we    = exp_data ? we : 1'b0;
        v.exp_wdata = wdata;
        v.exp_err   = exp_err;
        v.exp_out   = exp_err ? 32'h0 : rdata;
        return v;
    endfunction

    initial begin
        // Directed vectors
        vecs[0]  = mk(1, 0, 0, 32'h0000_0100, 32'h0,         32'h0,         2,  32'hDEAD_BEEF, 1, 0, 0);
        vecs[1]  = mk(0, 1, 1, 32'h0,         32'h0000_2000, 32'h1234_5678, 3,  32'h0000_0000, 0, 1, 0);
        vecs[2]  = mk(0, 1, 0, 32'h0,         32'h0000_3004, 32'h0,         0,  32'hA5A5_5A5A, 0, 1, 0);
        vecs[3]  = mk(1, 0, 0, 32'h0000_0200, 32'h0,         32'h0,         99, 32'h1111_1111, 0, 0, 1);
        vecs[4]  = mk(0, 1, 0, 32'h0,         32'h0000_0400, 32'h0,         99, 32'h2222_2222, 1, 1, 1);
        vecs[5]  = mk(1, 0, 0, 32'h0000_0300, 32'h0,         32'h0,         TO, 32'hCAFE_F00D, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 32'h0,         32'h0000_0A00, 32'h0BAD_CAFE, TO, 32'h0000_0000, 0, 1, 0);
        for (int r = 0; r < 4; r++) begin
            vecs[6 + r] = mk(1, 1, 0, 32'h0000_0500 + 32'(r * 4), 32'h0000_0600 + 32'(r * 4),
                             32'h0, 1, 32'h4000_0000 + 32'(r), 0,
                             RR ? (r % 2 == 0) : 1'b1, 0);
        end

        // Reset state, including a request pending through a clock edge.
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0F00;
        #2;
        check("rst_outputs", {mem_req_o, mem_we_o, inst_ack_o, data_ack_o, err_o}, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        @(posedge clk); #1;
        check("rst_no_grant", mem_req_o, 0);
        inst_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Request dropped right after its grant: access still completes.
        @(posedge clk); #1;
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0900;
        @(posedge clk); #1;
        inst_req_i  = 1'b0;
        @(negedge clk);
        check("drop_mem_req", mem_req_o, 1);
        @(posedge clk); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0909_0909;
        @(negedge clk);
        check("drop_ack", inst_ack_o, 1);
        check("drop_data", inst_o, 32'h0909_0909);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("drop_idle", mem_req_o, 0);
        $display("txn drop: inst addr=0x00000900 completes after early request drop");

        // Reset in the middle of a store.
        @(posedge clk); #1;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h0000_0700;
        data_wdata_i = 32'h0000_55AA;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_busy_we", mem_we_o, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        data_req_i  = 1'b0;
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0800;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hEEEE_EEEE;
        #1;
        check("mid_rst_ctrl", {mem_req_o, mem_we_o, inst_ack_o, data_ack_o, err_o}, 0);
        check("mid_rst_addr", mem_addr_o, 0);
        check("mid_rst_wdata", mem_wdata_o, 0);
        check("mid_rst_data_o", data_o, 0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        check("mid_rst_hold", mem_req_o, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_idle", mem_req_o, 0);
        @(negedge clk);
        check("post_rst_grant", mem_req_o, 1);
        check("post_rst_addr", mem_addr_o, 32'h0000_0800);
        check("post_rst_we", mem_we_o, 0);
        @(posedge clk); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        @(negedge clk);
        check("post_rst_ack", inst_ack_o, 1);
        check("post_rst_data", inst_o, 32'h1111_2222);
        @(posedge clk); #1;
        mem_ack_i  = 1'b0;
        inst_req_i = 1'b0;
        $display("txn reset: store abandoned, fetch addr=0x00000800 granted after release");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
